// File: rtl/music_seq_ctrl.sv
// Song sequencer: walks a {note_code, beats} song memory, presents each note
// to the frequency ROM and turns the returned divider preset into a square wave.
module music_seq_ctrl #(
  parameter int SONG_AW     = 5,
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int TONE_DIV    = 25,
  parameter int LOOP        = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  output logic [SONG_AW-1:0] song_addr,
  input  logic [15:0]        song_data,
  output logic [11:0]        note_code,
  input  logic [15:0]        origin,
  output logic               buzzer,
  output logic               playing,
  output logic               done
);
  // Duration counter must hold the longest note (15 beats) without truncation.
  localparam int DUR_W = $clog2(15 * BEAT_CYCLES + 1);
  localparam int DIV_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [DUR_W-1:0]   BEAT_C    = DUR_W'(BEAT_CYCLES);
  localparam logic [DUR_W-1:0]   GAP_C     = DUR_W'(GAP_CYCLES);
  localparam logic [SONG_AW-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  state_t             state, state_n;
  logic [SONG_AW-1:0] addr_n;
  logic [11:0]        note_n;
  logic [DUR_W-1:0]   dur_cnt, dur_n;
  logic               done_n;
  logic               song_end;
  logic [3:0]         beats;

  assign beats   = song_data[3:0];
  assign playing = (state != IDLE);

  // State and sequencer registers; rst wins over everything, including mid-note.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      song_addr <= '0;
      note_code <= '0;
      dur_cnt   <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      song_addr <= addr_n;
      note_code <= note_n;
      dur_cnt   <= dur_n;
      done      <= done_n;
    end
  end

  // Next-state logic: song end (marker or last address) loops or returns to IDLE;
  // stop overrides all of it without a done pulse.
  always_comb begin
    state_n  = state;
    addr_n   = song_addr;
    note_n   = note_code;
    dur_n    = dur_cnt;
    done_n   = 1'b0;
    song_end = 1'b0;
    case (state)
      IDLE: if (start && !stop) begin
        state_n = FETCH;
        addr_n  = '0;
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        if (beats == 4'd0) begin
          song_end = 1'b1;
        end else begin
          note_n  = song_data[15:4];
          dur_n   = DUR_W'(beats) * BEAT_C;
          state_n = PLAY;
        end
      end
      PLAY: begin
        dur_n = dur_cnt - DUR_W'(1);
        if (dur_cnt == DUR_W'(1)) begin
          if (song_addr == LAST_ADDR) begin
            song_end = 1'b1;
          end else begin
            addr_n  = song_addr + SONG_AW'(1);
            state_n = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (song_end) begin
      if (LOOP != 0) begin
        addr_n  = '0;
        state_n = FETCH;
      end else begin
        state_n = IDLE;
        note_n  = '0;
        done_n  = 1'b1;
      end
    end
    if (stop && state != IDLE) begin
      state_n = IDLE;
      addr_n  = song_addr;
      note_n  = '0;
      dur_n   = '0;
      done_n  = 1'b0;
    end
  end

  // Tone generator. The counter is (re)loaded on the first active PLAY cycle,
  // when origin already reflects the new note_code, so every note starts in phase.
  logic             rest, tone_active, tone_run, tone_tick, buzz_q;
  logic [13:0]      tone_cnt;
  logic [DIV_W-1:0] div_cnt;

  // Presets beyond the 14-bit counter range are treated as rests too.
  assign rest        = (origin[13:0] == 14'h3FFF) || (origin[15:14] != 2'b00);
  assign tone_active = (state == PLAY) && (dur_cnt > GAP_C) && !rest;
  assign tone_tick   = tone_run && (div_cnt == DIV_W'(TONE_DIV - 1));
  assign buzzer      = buzz_q && tone_active;

  // Tone counter and buzzer flop; held reloaded while muted or outside PLAY.
  always_ff @(posedge clk) begin
    if (rst) begin
      tone_cnt <= '0;
      div_cnt  <= '0;
      tone_run <= 1'b0;
      buzz_q   <= 1'b0;
    end else if (!tone_active) begin
      tone_cnt <= origin[13:0];
      div_cnt  <= '0;
      tone_run <= 1'b0;
      buzz_q   <= 1'b0;
    end else if (!tone_run) begin
      tone_cnt <= origin[13:0];
      div_cnt  <= '0;
      tone_run <= 1'b1;
      buzz_q   <= 1'b0;
    end else begin
      div_cnt <= tone_tick ? '0 : div_cnt + DIV_W'(1);
      if (tone_tick) begin
        if (tone_cnt == 14'h3FFF) begin
          tone_cnt <= origin[13:0];
          buzz_q   <= ~buzz_q;
        end else begin
          tone_cnt <= tone_cnt + 14'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_music_seq_ctrl.sv
// Scoreboard bench: a note-level song model expands each run into per-cycle
// expected observations; a monitor pops and compares one per clock.
module tb_music_seq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, stop0, start1, stop1;
  logic [2:0]  addr0, addr1;
  logic [15:0] data0, data1, org0, org1;
  logic [11:0] note0, note1;
  logic        buz0, buz1, play0, play1, done0, done1;
  logic [15:0] mem0 [8];
  logic [15:0] mem1 [8];

  typedef struct packed {
    logic        playing;
    logic [11:0] note;
    logic [2:0]  addr;
    logic        buzz;
    logic        done;
  } obs_t;

  obs_t  q0[$], q1[$], trace[$];
  obs_t  obs0, obs1;
  int    n_chk = 0, n_fail = 0;
  string cur = "reset";

  // Frequency ROM stand-in: code 0 and multiples of 5 are rests.
  function automatic logic [15:0] rom(input logic [11:0] c);
    if (c == 12'h000) return 16'd16383;
    return 16'd16383 - 16'(c % 5);
  endfunction

  assign org0 = rom(note0);
  assign org1 = rom(note1);
  assign obs0 = {play0, note0, addr0, buz0, done0};
  assign obs1 = {play1, note1, addr1, buz1, done1};

  // Synchronous song memories, one read cycle of latency.
  always @(posedge clk) begin
    data0 <= mem0[addr0];
    data1 <= mem1[addr1];
  end

  music_seq_ctrl #(.SONG_AW(3), .BEAT_CYCLES(16), .GAP_CYCLES(4), .TONE_DIV(1), .LOOP(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop(stop0), .song_addr(addr0), .song_data(data0),
    .note_code(note0), .origin(org0), .buzzer(buz0), .playing(play0), .done(done0));

  music_seq_ctrl #(.SONG_AW(3), .BEAT_CYCLES(16), .GAP_CYCLES(4), .TONE_DIV(1), .LOOP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .song_addr(addr1), .song_data(data1),
    .note_code(note1), .origin(org1), .buzzer(buz1), .playing(play1), .done(done1));

  task automatic check(input string nm, input obs_t got, input obs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s t=%0t: got play=%0b note=%h addr=%0d buz=%0b done=%0b, expected play=%0b note=%h addr=%0d buz=%0b done=%0b",
               cur, nm, $time, got.playing, got.note, got.addr, got.buzz, got.done,
               exp.playing, exp.note, exp.addr, exp.buzz, exp.done);
    end
  endtask

  // Monitor: one expected observation per cycle, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) check("dut0", obs0, q0.pop_front());
    if (q1.size() > 0) check("dut1", obs1, q1.pop_front());
  end

  // Note-level model: each note costs 2 overhead cycles plus beats*16 play cycles;
  // tone toggles every P=16384-origin cycles after a one-cycle load, muted in the last 4.
  task automatic build(input int d, input int stop_at, input int rst_at, input int max_len);
    int          addr, b, n, p;
    logic [11:0] note;
    logic [15:0] w;
    bit          fin, act, bz;
    obs_t        e;
    addr = 0; note = 12'h000; fin = 0;
    trace.delete();
    while (!fin && trace.size() < max_len) begin
      repeat (2) trace.push_back({1'b1, note, 3'(addr), 1'b0, 1'b0});
      w = (d == 1) ? mem1[addr] : mem0[addr];
      b = int'(w[3:0]);
      if (b != 0) begin
        note = w[15:4];
        n    = b * 16;
        p    = 16384 - int'(rom(note));
        for (int k = 0; k < n; k++) begin
          act = (k < n - 4) && (p != 1);
          bz  = act && (k >= 1) && ((((k - 1) / p) % 2) == 1);
          trace.push_back({1'b1, note, 3'(addr), bz, 1'b0});
        end
      end
      if (b == 0 || addr == 7) begin
        if (d == 1) addr = 0;
        else begin
          trace.push_back({1'b0, 12'h000, 3'(addr), 1'b0, 1'b1});
          fin = 1;
        end
      end else addr++;
    end
    if (fin) repeat (2) trace.push_back({1'b0, 12'h000, 3'(addr), 1'b0, 1'b0});
    if (stop_at >= 0 && stop_at < trace.size()) begin
      e = trace[stop_at];
      while (trace.size() > stop_at + 1) void'(trace.pop_back());
      trace.push_back({1'b0, 12'h000, e.addr, 1'b0, 1'b0});
    end
    if (rst_at >= 0 && rst_at < trace.size()) begin
      while (trace.size() > rst_at + 1) void'(trace.pop_back());
      trace.push_back(18'h0);
    end
  endtask

  // Driver: queue the expectation, pulse start, then apply stop/rst/spurious start.
  task automatic run(input int d, input int stop_at, input int rst_at, input int max_len,
                     input bit spur, input string name);
    int len;
    build(d, stop_at, rst_at, max_len);
    len = trace.size();
    @(negedge clk);
    cur = name;
    if (d == 0) begin q0 = trace; start0 = 1'b1; end
    else        begin q1 = trace; start1 = 1'b1; end
    for (int c = 0; c < len + 4; c++) begin
      @(negedge clk);
      if (d == 0) begin start0 = spur && (c == 1); stop0 = (c == stop_at); end
      else        begin start1 = spur && (c == 1); stop1 = (c == stop_at); end
      rst = (c == rst_at);
    end
    start0 = 1'b0; stop0 = 1'b0; start1 = 1'b0; stop1 = 1'b0; rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int d, sa, ml;
    logic [11:0] nc;
    rst = 1'b1; start0 = 1'b0; stop0 = 1'b0; start1 = 1'b0; stop1 = 1'b0;
    for (int i = 0; i < 8; i++) begin mem0[i] = 16'h0; mem1[i] = 16'h0; end
    repeat (3) @(negedge clk);
    check("reset0", obs0, 18'h0);
    check("reset1", obs1, 18'h0);
    rst = 1'b0;

    // Two notes then marker: h001 for 16 clk, h100 for 32, single done.
    mem0[0] = 16'h0011; mem0[1] = 16'h1002; mem0[2] = 16'h0000;
    run(0, -1, -1, 100000, 0, "song3");

    // Rest note: buzzer silent for the whole beat.
    mem0[0] = 16'h0001; mem0[1] = 16'h0000;
    run(0, -1, -1, 100000, 0, "rest");

    // Eight full words, no marker: ends after addr 7; spurious start ignored.
    for (int i = 0; i < 8; i++) mem0[i] = {12'(i * 37 + 1), 4'd1};
    run(0, -1, -1, 100000, 1, "full8");

    // Looping song with marker at addr 2, stopped after several passes.
    mem1[0] = 16'h0011; mem1[1] = 16'h0031; mem1[2] = 16'h0000;
    run(1, 120, -1, 121, 0, "loop");

    // Reset in the middle of the first note.
    mem0[0] = 16'h0011; mem0[1] = 16'h1002; mem0[2] = 16'h0000;
    run(0, -1, 10, 100000, 0, "rst_mid");

    // start and stop together in IDLE: nothing happens.
    @(negedge clk);
    cur = "start_stop";
    repeat (2) q0.push_back(18'h0);
    start0 = 1'b1; stop0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; stop0 = 1'b0;
    repeat (2) @(negedge clk);

    // Stop in the middle of the second note.
    run(0, 25, -1, 100000, 0, "stop_play");

    // Randomised songs on both variants.
    for (int it = 0; it < 12; it++) begin
      d = int'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        nc = 12'($urandom);
        if (d == 0) mem0[i] = {nc, ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 3))};
        else        mem1[i] = {nc, ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 3))};
      end
      if (d == 0) begin
        sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 300)) : -1;
        ml = 100000;
      end else begin
        sa = int'($urandom_range(10, 400));
        ml = sa + 1;
      end
      run(d, sa, -1, ml, bit'($urandom_range(0, 1)), $sformatf("rand%0d", it));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
